dec_ram_bank_ctrl: RTL
======================

# dec_ram_bank_ctrl

Ping-pong bank scheduler for the two-bank decoder RAM (bank select `rs`, single shared address/data port, registered read data). Channel bits stream into the fill bank while the LDPC decoder core reads the other, full bank. The controller arbitrates the single RAM port between the two sides and swaps banks on frame completion and decode completion. It sits between the channel input stream and the decoder core and is the only master of the RAM control pins.

## Interface

- `DATA_WIDTH`, 1: bits per RAM word; matches the RAM.
- `ADDR_WIDTH`, 8: RAM address width.
- `CODE_LEN`, 256: words per frame; legal range 2..2^ADDR_WIDTH.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  channel word present.
- `in_data`  in  DATA_WIDTH  channel word.
- `in_ready`  out  1  write accepted this cycle when `in_valid & in_ready`.
- `frame_ready`  out  1  decode bank holds a complete frame.
- `rd_req`  in  1  decoder read request.
- `rd_addr`  in  ADDR_WIDTH  word index within the decode bank.
- `rd_ready`  out  1  equals `frame_ready`.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_data`  out  DATA_WIDTH  read word; pass-through of `ram_dout`.
- `dec_done`  in  1  one-cycle pulse: decode finished, release the bank.
- `frame_loaded`  out  1  one-cycle pulse: fill bank completed.
- `protocol_err`  out  1  sticky; set on `dec_done` while `!frame_ready`.
- `ram_addr`  out  ADDR_WIDTH  registered RAM address.
- `ram_din`  out  DATA_WIDTH  registered RAM write data.
- `ram_we`, `ram_cs`, `ram_rs`  out  1 each  registered RAM write enable, chip select, bank select.
- `ram_dout`  in  DATA_WIDTH  RAM registered read data.

## Operation

- State:
  - `fill_bank` and `dec_bank` (1 bit each).
  - `bank_full[1:0]`.
  - write counter `wcnt` (0..CODE_LEN-1).
  - 2-stage read-valid pipeline.
  - `protocol_err`.
- `frame_ready = bank_full[dec_bank]`.
- `rd_ready = frame_ready`.
- `in_ready = !bank_full[fill_bank] & !(rd_req & rd_ready)`. Reads have strict priority over writes, and `in_ready` is combinational from `rd_req` and state.
- Accepted read (`rd_req & rd_ready`): next cycle `ram_cs=1`, `ram_we=0`, `ram_rs=dec_bank`, `ram_addr=rd_addr`.
- Accepted write: next cycle `ram_cs=1`, `ram_we=1`, `ram_rs=fill_bank`, `ram_addr=wcnt`, `ram_din=in_data`. Then `wcnt++`.
- Idle cycle: next cycle `ram_cs=0` and `ram_we=0`. `ram_addr`, `ram_rs` and `ram_din` hold their values.
- Frame completion: a write accepted with `wcnt==CODE_LEN-1` does all of the following:
  - sets `bank_full[fill_bank]`;
  - toggles `fill_bank`;
  - clears `wcnt`;
  - pulses `frame_loaded` the next cycle.
- Release: `dec_done & frame_ready` clears `bank_full[dec_bank]` and toggles `dec_bank`.
- `dec_done & !frame_ready` is ignored for state and sets `protocol_err` until reset.
- Both banks full: `in_ready=0`. Writing resumes the cycle after a release.
- `rd_addr >= CODE_LEN`: the read is passed to the RAM unchanged; no check is made.

## Timing

- Reset values:
  - `fill_bank=0`, `dec_bank=0`, `bank_full=00`, `wcnt=0`.
  - `ram_cs=0`, `ram_we=0`, `ram_rs=0`, `ram_addr=0`, `ram_din=0`.
  - `rd_valid=0`, `frame_loaded=0`, `protocol_err=0`.
  - Consequently `in_ready=1` and `frame_ready=0`.
- Read latency: read accepted at cycle t → RAM command at t+1 → `rd_valid=1` with `rd_data` at t+2. Back-to-back reads give one result per cycle.
- Write latency: write accepted at t → RAM write at the end of t+1.
- Frame latency: last word accepted at t → `frame_loaded=1` and `frame_ready=1` at t+1, provided the decode bank was previously empty. Reads may be accepted from t+1; that bank's final write lands at the end of t+1, so a read issued at t+2 or later sees it.
- Releasing the last-written bank: `dec_done` at t → `frame_ready` reflects the other bank at t+1.
- Simultaneous events:
  - Frame completion and `dec_done` in the same cycle always target different banks. Both apply.
  - `dec_done` together with an accepted read: the read completes normally.
- Reset mid-operation: all frames are discarded and the `rd_valid` pipeline is flushed. A read accepted in the reset cycle produces no `rd_valid`.

## Test plan

- **Reset defaults.** Reset, then idle 3 cycles → `in_ready=1`, `frame_ready=0`, `ram_cs=0`, `protocol_err=0`.
- **First frame load.** With CODE_LEN=4, stream 1,0,1,1 with continuous `in_valid`:
  - RAM writes to bank 0 at addresses 0..3.
  - `frame_loaded` pulses once, and `frame_ready=1` the cycle after the 4th accept.
  - Next frame writes go to `ram_rs=1`.
- **Read priority and ordering.** Hold `in_valid=1`; read addresses 3,0 back-to-back:
  - `in_ready=0` in both request cycles.
  - `rd_valid` fires 2 cycles after each request with data 1 then 1.
  - Write addresses continue without skip.
- **Both banks full.** Fill frames A and B → `in_ready=0`. Pulse `dec_done` → `dec_bank=1`, `frame_ready=1`, and `in_ready=1` the next cycle, with writes to bank 0.
- **Spurious done and reset flush.** `dec_done` with `frame_ready=0` → `protocol_err=1` with no bank change. Assert `rst` one cycle after a read accept → no `rd_valid`, and all reset values are restored.

Source files
------------

// File: rtl/dec_ram_bank_ctrl_if.sv
// Bus bundle between the ping-pong bank controller, the channel stream, the decoder core and the RAM.
// The master modport is the controller's view; the slave modport is the environment's view.
interface dec_ram_bank_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  frame_ready;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  dec_done;
    logic                  frame_loaded;
    logic                  protocol_err;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic                  ram_cs;
    logic                  ram_rs;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        input  in_valid, in_data, rd_req, rd_addr, dec_done, ram_dout,
        output in_ready, frame_ready, rd_ready, rd_valid, rd_data,
               frame_loaded, protocol_err, ram_addr, ram_din, ram_we, ram_cs, ram_rs
    );

    modport slave (
        output in_valid, in_data, rd_req, rd_addr, dec_done, ram_dout,
        input  in_ready, frame_ready, rd_ready, rd_valid, rd_data,
               frame_loaded, protocol_err, ram_addr, ram_din, ram_we, ram_cs, ram_rs
    );
endinterface

// File: rtl/dec_ram_bank_ctrl.sv
// Ping-pong scheduler for the two-bank decoder RAM: the channel fills one bank while the
// decoder reads the other; reads win the single RAM port, banks swap on frame/decode completion.
module dec_ram_bank_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int CODE_LEN   = 256
) (
    input  logic                clk,
    input  logic                rst,
    dec_ram_bank_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(CODE_LEN - 1);

    logic                  fill_bank;
    logic                  dec_bank;
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_nxt;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic                  rd_issued;
    logic                  rd_valid_q;
    logic                  frame_loaded_q;
    logic                  protocol_err_q;

    logic frame_ready;
    logic rd_accept;
    logic wr_accept;
    logic frame_done;
    logic dec_release;

    assign frame_ready = bank_full[dec_bank];
    assign rd_accept   = bus.rd_req & frame_ready;
    assign wr_accept   = bus.in_valid & ~bank_full[fill_bank] & ~rd_accept;
    assign frame_done  = wr_accept & (wcnt == LAST_WORD);
    assign dec_release = bus.dec_done & frame_ready;

    assign bus.frame_ready  = frame_ready;
    assign bus.rd_ready     = frame_ready;
    assign bus.in_ready     = ~bank_full[fill_bank] & ~rd_accept;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = bus.ram_dout;
    assign bus.frame_loaded = frame_loaded_q;
    assign bus.protocol_err = protocol_err_q;

    // Completion and release can coincide only on different banks, so both updates always apply.
    always_comb begin
        // NOTE: every variable gets its default before any branch, so no path can infer a latch.
        bank_full_nxt = bank_full;
        if (frame_done)  bank_full_nxt[fill_bank] = 1'b1;
        if (dec_release) bank_full_nxt[dec_bank]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            fill_bank      <= 1'b0;
            dec_bank       <= 1'b0;
            bank_full      <= 2'b00;
            wcnt           <= '0;
            rd_issued      <= 1'b0;
            rd_valid_q     <= 1'b0;
            frame_loaded_q <= 1'b0;
            protocol_err_q <= 1'b0;
            bus.ram_cs     <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_rs     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_din    <= '0;
        end else begin
            bank_full      <= bank_full_nxt;
            rd_issued      <= rd_accept;
            rd_valid_q     <= rd_issued;
            frame_loaded_q <= frame_done;
            protocol_err_q <= protocol_err_q | (bus.dec_done & ~frame_ready);
            bus.ram_cs     <= rd_accept | wr_accept;
            bus.ram_we     <= wr_accept;

            // Address, bank and data hold on idle cycles; a read leaves the write data untouched.
            if (rd_accept) begin
                bus.ram_rs   <= dec_bank;
                bus.ram_addr <= bus.rd_addr;
            end else if (wr_accept) begin
                bus.ram_rs   <= fill_bank;
                bus.ram_addr <= wcnt;
                bus.ram_din  <= bus.in_data;
            end

            if (frame_done) begin
                wcnt      <= '0;
                fill_bank <= ~fill_bank;
            end else if (wr_accept) begin
                wcnt <= wcnt + 1'b1;
            end

            if (dec_release) dec_bank <= ~dec_bank;
        end
    end
endmodule
